umtrx_rx_sample_mux: RTL and testbench
======================================

Name: umtrx_rx_sample_mux

Overview:
Parametrised multi-channel RX sample collector for UmTRX-class designs. It gathers NCH DDC sample streams, each qualified by its own strobe and by the shared adc_stb. Every accepted sample is timestamped with vita_time and buffered in a per-channel FIFO. A round-robin arbiter merges the FIFOs into one tagged, backpressured stream that feeds a single VITA framer. Per-channel run/clear control comes from the settings bus, so this one block replaces per-channel strobe, run and clear glue.

Parameters:
NCH, 2, number of input channels (1..4)
SWIDTH, 32, sample width (packed I/Q)
CHW, 2, width of channel tag; NCH <= 2**CHW
DEPTH_LOG2, 4, per-channel FIFO depth = 2**DEPTH_LOG2 entries
BASE, 0, settings-bus base address

Ports:
clk  in  1  single clock for all logic
rst  in  1  synchronous, active-high reset
set_stb  in  1  settings write strobe
set_addr  in  8  settings address
set_data  in  32  settings data
adc_stb  in  1  shared sample-rate qualifier
in_sample  in  NCH*SWIDTH  channel k at bits [k*SWIDTH +: SWIDTH]
in_strobe  in  NCH  per-channel sample valid
vita_time  in  64  current time, sampled at acceptance
run_o  out  NCH  per-channel run, drives DDC run
clear_o  out  NCH  one-cycle per-channel clear pulse, drives DDC clear
overrun  out  NCH  sticky per-channel overflow flag
o_tdata  out  CHW+SWIDTH  {channel tag, sample}
o_time  out  64  timestamp of the o_tdata sample
o_tvalid  out  1  output valid
o_tready  in  1  output ready

Behaviour:
- Reset values:
  - run_o=0, clear_o=0, overrun=0, o_tvalid=0, o_tdata=0, o_time=0.
  - All FIFOs empty; round-robin pointer = 0; enable register = 0.
- Settings registers (write-only; only set_data[NCH-1:0] is used):
  - BASE+0: enable mask. run_o equals the enable mask, registered: it updates the cycle after set_stb.
  - BASE+1: clear request. For each set bit k, clear_o[k] pulses high for exactly 1 cycle, starting the cycle after set_stb. The same edge empties FIFO k and clears overrun[k]. The enable mask is unchanged.
  - Other addresses are ignored.
- Acceptance: channel k accepts when in_strobe[k] & adc_stb & run_o[k] & ~clear_o[k].
  - The FIFO entry is {in_sample[k], vita_time}, captured on the same edge.
  - Strobes are ignored when adc_stb=0 or the channel is disabled.
- FIFO full:
  - Acceptance into a full FIFO drops the sample and sets overrun[k]. overrun[k] holds until a clear of channel k or rst.
  - If the same FIFO is popped in that cycle, the write succeeds and no overrun is flagged.
- Output stage: a single register holding tag, sample and time. It may load when o_tvalid=0, or when o_tvalid & o_tready (back-to-back, 1 word/cycle).
  - Grant goes to the first non-empty FIFO searching upward from the pointer, with wrap-around.
  - On grant: pop that FIFO, load the output, and set pointer = granted+1 mod NCH.
  - With no non-empty FIFO, o_tvalid drops after the handshake.
- o_tdata and o_time are held stable while o_tvalid & ~o_tready.
- Latency: a sample accepted at edge N into an empty FIFO, with the output stage idle, gives o_tvalid high from cycle N+2.
- Disabling a channel stops acceptance only; its buffered samples still drain.
- Clear mid-operation: a word already in the output register is not affected. Words still in FIFO k are discarded.
- Simultaneous clear request and acceptance on the same channel: the clear wins and the sample is dropped without setting overrun.
- Timestamps are stored unmodified; no arithmetic is applied.

Test Plan:
- Reset then enable mask 2'b01: strobe ch0 with adc_stb=1, sample 0xA5A5_0001, vita_time=100 → o_tvalid at N+2, o_tdata={2'd0,0xA5A50001}, o_time=100. Strobes on ch1 produce no output.
- Gating: ch0 enabled, in_strobe=1 with adc_stb toggling 1,0,1,0 for 8 cycles, o_tready=1 → exactly 4 output words, timestamps equal to vita_time at each adc_stb=1 cycle.
- Fairness: NCH=2, both enabled, 3 samples queued per channel, o_tready=1 → tag order 0,1,0,1,0,1, with no bubble between words.
- Overflow: DEPTH_LOG2=2, o_tready=0, 6 strobes on ch1 → 4 stored plus 1 in the output register, 6th dropped, overrun[1]=1. Release o_tready → 5 words out in order; overrun stays 1.
- Clear: with 3 words queued in ch0 and o_tready=0, write BASE+1=1 → clear_o[0] pulses 1 cycle, overrun[0]=0. After release only the word already in the output register emerges.
- Backpressure and reset: hold o_tready=0 for 10 cycles → o_tdata and o_time remain constant. Assert rst mid-stream → next cycle o_tvalid=0, run_o=0, all FIFOs empty.

Source files
------------

// File: rtl/umtrx_rx_sample_mux.sv
// Multi-channel RX sample collector.
// Each DDC channel k is qualified by in_strobe[k] & adc_stb & run_o[k] & ~clear_o[k].
// Every accepted sample is stored together with vita_time in a per-channel FIFO.
// A round-robin arbiter merges the FIFOs into one tagged, backpressured stream.
//
// Ports:
//   clk, rst            single clock, synchronous active-high reset
//   set_stb/addr/data   settings writes: BASE+0 enable mask, BASE+1 clear request
//   adc_stb             shared sample-rate qualifier
//   in_sample           NCH packed samples, channel k at [k*SWIDTH +: SWIDTH]
//   in_strobe           per-channel sample valid
//   vita_time           timestamp captured with each accepted sample
//   run_o               per-channel run (registered enable mask)
//   clear_o             one-cycle per-channel clear pulse
//   overrun             sticky per-channel FIFO overflow flag
//   o_tdata/o_time      {tag, sample} and its timestamp
//   o_tvalid/o_tready   output handshake
module umtrx_rx_sample_mux #(
  parameter int unsigned NCH        = 2,
  parameter int unsigned SWIDTH     = 32,
  parameter int unsigned CHW        = 2,
  parameter int unsigned DEPTH_LOG2 = 4,
  parameter int unsigned BASE       = 0
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  set_stb,
  input  logic [7:0]            set_addr,
  input  logic [31:0]           set_data,
  input  logic                  adc_stb,
  input  logic [NCH*SWIDTH-1:0] in_sample,
  input  logic [NCH-1:0]        in_strobe,
  input  logic [63:0]           vita_time,
  output logic [NCH-1:0]        run_o,
  output logic [NCH-1:0]        clear_o,
  output logic [NCH-1:0]        overrun,
  output logic [CHW+SWIDTH-1:0] o_tdata,
  output logic [63:0]           o_time,
  output logic                  o_tvalid,
  input  logic                  o_tready
);

  localparam int unsigned Depth      = 2 ** DEPTH_LOG2;
  localparam int unsigned EntryW     = SWIDTH + 64;
  localparam logic [7:0]  AddrEnable = 8'(BASE);
  localparam logic [7:0]  AddrClear  = 8'(BASE + 1);

  // One extra pointer bit distinguishes full from empty.
  typedef logic [DEPTH_LOG2:0] ptr_t;

  logic [NCH-1:0] run_q, run_d;
  logic [NCH-1:0] clear_q, clear_d;
  logic [NCH-1:0] overrun_q, overrun_d;

  ptr_t wr_ptr_q [NCH];
  ptr_t wr_ptr_d [NCH];
  ptr_t rd_ptr_q [NCH];
  ptr_t rd_ptr_d [NCH];

  logic [EntryW-1:0] mem_q [NCH][Depth];
  logic [EntryW-1:0] head [NCH];

  logic [NCH-1:0] clr_req, accept, empty, full, avail, pop, push, ovf_set;

  logic [CHW-1:0]    rr_q, rr_d;
  logic [CHW-1:0]    grant_idx;
  logic              grant_vld;
  logic [EntryW-1:0] grant_entry;
  logic              load_en;

  logic                  out_vld_q, out_vld_d;
  logic [CHW+SWIDTH-1:0] out_data_q, out_data_d;
  logic [63:0]           out_time_q, out_time_d;

  logic unused_set_data;
  assign unused_set_data = ^set_data[31:NCH];

  // Per-channel status.
  always_comb begin
    for (int k = 0; k < NCH; k++) begin
      clr_req[k] = set_stb && (set_addr == AddrClear) && set_data[k];
      accept[k]  = in_strobe[k] && adc_stb && run_q[k] && !clear_q[k];
      empty[k]   = (wr_ptr_q[k] == rd_ptr_q[k]);
      full[k]    = (wr_ptr_q[k][DEPTH_LOG2] != rd_ptr_q[k][DEPTH_LOG2]) &&
                   (wr_ptr_q[k][DEPTH_LOG2-1:0] == rd_ptr_q[k][DEPTH_LOG2-1:0]);
      // A channel being cleared this cycle is not granted: its contents are discarded.
      avail[k]   = !empty[k] && !clr_req[k];
      head[k]    = mem_q[k][rd_ptr_q[k][DEPTH_LOG2-1:0]];
    end
  end

  // Round-robin grant: lowest available channel at or above rr_q, else lowest overall.
  always_comb begin
    grant_vld   = 1'b0;
    grant_idx   = '0;
    grant_entry = '0;
    for (int k = NCH - 1; k >= 0; k--) begin
      if (avail[k] && (CHW'(k) >= rr_q)) begin
        grant_vld = 1'b1;
        grant_idx = CHW'(k);
      end
    end
    if (!grant_vld) begin
      for (int k = NCH - 1; k >= 0; k--) begin
        if (avail[k]) begin
          grant_vld = 1'b1;
          grant_idx = CHW'(k);
        end
      end
    end
    for (int k = 0; k < NCH; k++) begin
      if (grant_idx == CHW'(k)) begin
        grant_entry = head[k];
      end
    end
  end

  // Next-state logic.
  always_comb begin
    load_en    = !out_vld_q || o_tready;
    run_d      = run_q;
    clear_d    = clr_req;
    out_vld_d  = out_vld_q;
    out_data_d = out_data_q;
    out_time_d = out_time_q;
    rr_d       = rr_q;

    if (set_stb && (set_addr == AddrEnable)) begin
      run_d = set_data[NCH-1:0];
    end

    if (load_en) begin
      out_vld_d = grant_vld;
      if (grant_vld) begin
        out_data_d = {grant_idx, grant_entry[EntryW-1:64]};
        out_time_d = grant_entry[63:0];
        rr_d       = (grant_idx == CHW'(NCH - 1)) ? '0 : grant_idx + CHW'(1);
      end
    end

    for (int k = 0; k < NCH; k++) begin
      pop[k]       = load_en && grant_vld && (grant_idx == CHW'(k));
      // A pop in the same cycle frees the slot, so a full FIFO still takes the write.
      push[k]      = accept[k] && !clr_req[k] && (!full[k] || pop[k]);
      ovf_set[k]   = accept[k] && !clr_req[k] && full[k] && !pop[k];
      overrun_d[k] = (overrun_q[k] && !clr_req[k]) || ovf_set[k];
      wr_ptr_d[k]  = wr_ptr_q[k] + ptr_t'(push[k]);
      rd_ptr_d[k]  = clr_req[k] ? wr_ptr_q[k] : rd_ptr_q[k] + ptr_t'(pop[k]);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      run_q      <= '0;
      clear_q    <= '0;
      overrun_q  <= '0;
      rr_q       <= '0;
      out_vld_q  <= 1'b0;
      out_data_q <= '0;
      out_time_q <= '0;
      for (int k = 0; k < NCH; k++) begin
        wr_ptr_q[k] <= '0;
        rd_ptr_q[k] <= '0;
      end
    end else begin
      run_q      <= run_d;
      clear_q    <= clear_d;
      overrun_q  <= overrun_d;
      rr_q       <= rr_d;
      out_vld_q  <= out_vld_d;
      out_data_q <= out_data_d;
      out_time_q <= out_time_d;
      for (int k = 0; k < NCH; k++) begin
        wr_ptr_q[k] <= wr_ptr_d[k];
        rd_ptr_q[k] <= rd_ptr_d[k];
      end
    end
  end

  // FIFO storage needs no reset; validity is tracked by the pointers.
  always_ff @(posedge clk) begin
    for (int k = 0; k < NCH; k++) begin
      if (push[k]) begin
        mem_q[k][wr_ptr_q[k][DEPTH_LOG2-1:0]] <= {in_sample[k*SWIDTH +: SWIDTH], vita_time};
      end
    end
  end

  assign run_o    = run_q;
  assign clear_o  = clear_q;
  assign overrun  = overrun_q;
  assign o_tvalid = out_vld_q;
  assign o_tdata  = out_data_q;
  assign o_time   = out_time_q;

endmodule

// File: tb/tb_umtrx_rx_sample_mux.sv
module tb_umtrx_rx_sample_mux;

  localparam int unsigned NCH   = 2;
  localparam int unsigned SW    = 32;
  localparam int unsigned CHW   = 2;
  localparam int unsigned DL2   = 2;
  localparam int unsigned DEPTH = 4;
  localparam int unsigned BASE  = 16;

  logic          clk = 1'b0;
  logic          rst;
  logic          set_stb;
  logic [7:0]    set_addr;
  logic [31:0]   set_data;
  logic          adc_stb;
  logic [63:0]   in_sample;
  logic [1:0]    in_strobe;
  logic [63:0]   vita_time;
  logic [1:0]    run_o, clear_o, overrun;
  logic [33:0]   o_tdata;
  logic [63:0]   o_time;
  logic          o_tvalid;
  logic          o_tready;

  umtrx_rx_sample_mux #(
    .NCH(NCH), .SWIDTH(SW), .CHW(CHW), .DEPTH_LOG2(DL2), .BASE(BASE)
  ) dut (
    .clk(clk), .rst(rst), .set_stb(set_stb), .set_addr(set_addr), .set_data(set_data),
    .adc_stb(adc_stb), .in_sample(in_sample), .in_strobe(in_strobe), .vita_time(vita_time),
    .run_o(run_o), .clear_o(clear_o), .overrun(overrun), .o_tdata(o_tdata), .o_time(o_time),
    .o_tvalid(o_tvalid), .o_tready(o_tready)
  );

  always #5 clk = ~clk;

  int n_cmp  = 0;
  int n_fail = 0;
  bit cmp_en = 1'b0;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- Reference model: per-channel queues of {sample, time} ----------------
  logic [95:0] mq0[$];
  logic [95:0] mq1[$];
  logic [1:0]  m_run, m_clr, m_ovr;
  logic        m_valid;
  logic [33:0] m_tdata;
  logic [63:0] m_time;
  int          m_rr;

  function automatic int qsize(input int k);
    return (k == 0) ? mq0.size() : mq1.size();
  endfunction

  always @(posedge clk) begin
    logic [1:0]  clr;
    logic [95:0] e;
    bit          load, acc;
    int          g, c;
    if (rst) begin
      mq0.delete(); mq1.delete();
      m_run = 0; m_clr = 0; m_ovr = 0; m_valid = 0; m_tdata = 0; m_time = 0; m_rr = 0;
    end else begin
      clr  = (set_stb && set_addr == 8'(BASE + 1)) ? set_data[1:0] : 2'b00;
      load = !m_valid || o_tready;
      g    = -1;
      if (load) begin
        for (int i = 0; i < NCH; i++) begin
          c = (m_rr + i) % NCH;
          if (g < 0 && qsize(c) > 0 && !clr[c]) g = c;
        end
        if (g >= 0) begin
          e = (g == 0) ? mq0.pop_front() : mq1.pop_front();
          m_valid = 1'b1;
          m_tdata = {2'(g), e[95:64]};
          m_time  = e[63:0];
          m_rr    = (g + 1) % NCH;
        end else begin
          m_valid = 1'b0;
        end
      end
      for (int k = 0; k < NCH; k++) begin
        acc = in_strobe[k] && adc_stb && m_run[k] && !m_clr[k];
        if (clr[k]) begin
          if (k == 0) mq0.delete(); else mq1.delete();
          m_ovr[k] = 1'b0;
        end else if (acc) begin
          if (qsize(k) < DEPTH) begin
            if (k == 0) mq0.push_back({in_sample[31:0], vita_time});
            else        mq1.push_back({in_sample[63:32], vita_time});
          end else begin
            m_ovr[k] = 1'b1;
          end
        end
      end
      m_clr = clr;
      if (set_stb && set_addr == 8'(BASE)) m_run = set_data[1:0];
    end
  end

  // Every-cycle comparison against the model.
  always @(negedge clk) begin
    if (cmp_en) begin
      check("run_o", 128'(run_o), 128'(m_run));
      check("clear_o", 128'(clear_o), 128'(m_clr));
      check("overrun", 128'(overrun), 128'(m_ovr));
      check("o_tvalid", 128'(o_tvalid), 128'(m_valid));
      if (m_valid) begin
        check("o_tdata", 128'(o_tdata), 128'(m_tdata));
        check("o_time", 128'(o_time), 128'(m_time));
      end
    end
  end

  // Log of completed output handshakes.
  typedef struct {
    logic [1:0]  tag;
    logic [31:0] s;
    logic [63:0] t;
    int          cyc;
  } word_t;
  word_t wlog[$];
  int    cyc = 0;

  always @(posedge clk) begin
    if (!rst && o_tvalid === 1'b1 && o_tready === 1'b1)
      wlog.push_back('{tag: o_tdata[33:32], s: o_tdata[31:0], t: o_time, cyc: cyc});
    cyc++;
  end

  // ---------------- Stimulus ----------------
  task automatic step();
    @(negedge clk);
  endtask

  task automatic idle();
    in_strobe = 2'b00;
    adc_stb   = 1'b0;
    set_stb   = 1'b0;
  endtask

  task automatic wr_set(input logic [7:0] a, input logic [31:0] d);
    set_stb  = 1'b1;
    set_addr = a;
    set_data = d;
    step();
    set_stb  = 1'b0;
  endtask

  initial begin
    rst = 1'b1; o_tready = 1'b1; set_addr = 0; set_data = 0;
    in_sample = 0; vita_time = 0;
    idle();
    step();
    cmp_en = 1'b1;
    step();
    check("rst_tvalid", 128'(o_tvalid), 128'(0));
    check("rst_run", 128'(run_o), 128'(0));
    check("rst_tdata", 128'(o_tdata), 128'(0));
    check("rst_time", 128'(o_time), 128'(0));
    rst = 1'b0;
    step();

    // Basic latency and tagging.
    wlog.delete();
    wr_set(8'(BASE), 32'h1);
    check("en_run", 128'(run_o), 128'(2'b01));
    in_strobe = 2'b01; adc_stb = 1'b1; in_sample = {32'h0, 32'hA5A5_0001}; vita_time = 100;
    step();
    idle();
    check("lat_n1_tvalid", 128'(o_tvalid), 128'(0));
    step();
    check("lat_n2_tvalid", 128'(o_tvalid), 128'(1));
    check("lat_tdata", 128'(o_tdata), 128'({2'd0, 32'hA5A5_0001}));
    check("lat_time", 128'(o_time), 128'(100));
    step();
    in_strobe = 2'b10; adc_stb = 1'b1;
    repeat (4) step();
    idle();
    repeat (3) step();
    check("ch1_disabled_words", 128'(wlog.size()), 128'(1));

    // adc_stb gating.
    wlog.delete();
    in_strobe = 2'b01;
    for (int i = 0; i < 8; i++) begin
      adc_stb = (i % 2 == 0);
      vita_time = 64'(200 + i);
      in_sample[31:0] = 32'hB000 + 32'(i);
      step();
    end
    idle();
    repeat (4) step();
    check("gate_words", 128'(wlog.size()), 128'(4));
    for (int j = 0; j < 4 && j < wlog.size(); j++) begin
      check("gate_time", 128'(wlog[j].t), 128'(200 + 2 * j));
      check("gate_sample", 128'(wlog[j].s), 128'(32'hB000 + 32'(2 * j)));
    end

    // Round-robin fairness.
    rst = 1'b1; step(); rst = 1'b0;
    wr_set(8'(BASE), 32'h3);
    o_tready = 1'b0;
    wlog.delete();
    for (int i = 0; i < 3; i++) begin
      in_strobe = 2'b11; adc_stb = 1'b1;
      in_sample = {32'h200 + 32'(i), 32'h100 + 32'(i)};
      vita_time = 64'(300 + i);
      step();
    end
    idle();
    repeat (2) step();
    o_tready = 1'b1;
    repeat (8) step();
    check("rr_words", 128'(wlog.size()), 128'(6));
    for (int j = 0; j < 6 && j < wlog.size(); j++) begin
      check("rr_tag", 128'(wlog[j].tag), 128'(j % 2));
      check("rr_sample", 128'(wlog[j].s),
            128'(((j % 2) != 0 ? 32'h200 : 32'h100) + 32'(j / 2)));
      if (j > 0) check("rr_no_bubble", 128'(wlog[j].cyc), 128'(wlog[j-1].cyc + 1));
    end

    // Overflow on ch1.
    wr_set(8'(BASE), 32'h2);
    o_tready = 1'b0;
    wlog.delete();
    for (int i = 0; i < 6; i++) begin
      in_strobe = 2'b10; adc_stb = 1'b1;
      in_sample[63:32] = 32'hC00 + 32'(i);
      vita_time = 64'(400 + i);
      step();
    end
    idle();
    repeat (2) step();
    check("ovf_flag", 128'(overrun), 128'(2'b10));
    o_tready = 1'b1;
    repeat (8) step();
    check("ovf_words", 128'(wlog.size()), 128'(5));
    for (int j = 0; j < 5 && j < wlog.size(); j++)
      check("ovf_sample", 128'(wlog[j].s), 128'(32'hC00 + 32'(j)));
    check("ovf_sticky", 128'(overrun), 128'(2'b10));

    // Clear on ch0, with a simultaneous sample that must be dropped.
    wr_set(8'(BASE), 32'h1);
    o_tready = 1'b0;
    wlog.delete();
    for (int i = 0; i < 6; i++) begin
      in_strobe = 2'b01; adc_stb = 1'b1;
      in_sample[31:0] = 32'hD00 + 32'(i);
      vita_time = 64'(500 + i);
      step();
    end
    idle();
    step();
    check("clr_pre_ovf", 128'(overrun), 128'(2'b11));
    in_strobe = 2'b01; adc_stb = 1'b1; in_sample[31:0] = 32'hDEAD;
    wr_set(8'(BASE + 1), 32'h1);
    check("clr_pulse", 128'(clear_o), 128'(2'b01));
    check("clr_ovf", 128'(overrun), 128'(2'b10));
    check("clr_run_kept", 128'(run_o), 128'(2'b01));
    step();
    idle();
    check("clr_pulse_end", 128'(clear_o), 128'(2'b00));
    o_tready = 1'b1;
    repeat (6) step();
    check("clr_words", 128'(wlog.size()), 128'(1));
    if (wlog.size() > 0) check("clr_sample", 128'(wlog[0].s), 128'(32'hD00));

    // Backpressure hold, then reset mid-stream.
    o_tready = 1'b0;
    wlog.delete();
    for (int i = 0; i < 3; i++) begin
      in_strobe = 2'b01; adc_stb = 1'b1;
      in_sample[31:0] = 32'hE00 + 32'(i);
      vita_time = 64'(600 + i);
      step();
    end
    idle();
    for (int i = 0; i < 10; i++) begin
      check("bp_tvalid", 128'(o_tvalid), 128'(1));
      check("bp_tdata", 128'(o_tdata), 128'({2'd0, 32'hE00}));
      check("bp_time", 128'(o_time), 128'(600));
      step();
    end
    rst = 1'b1;
    step();
    check("mid_rst_tvalid", 128'(o_tvalid), 128'(0));
    check("mid_rst_run", 128'(run_o), 128'(0));
    rst = 1'b0;
    o_tready = 1'b1;
    in_strobe = 2'b01; adc_stb = 1'b1;
    repeat (4) step();
    idle();
    repeat (3) step();
    check("mid_rst_empty", 128'(wlog.size()), 128'(0));

    // Randomized traffic against the model.
    wr_set(8'(BASE), 32'h3);
    for (int i = 0; i < 3000; i++) begin
      in_strobe = 2'($urandom);
      adc_stb   = ($urandom_range(0, 3) != 0);
      o_tready  = ($urandom_range(0, 3) != 0);
      in_sample = {$urandom, $urandom};
      vita_time = vita_time + 64'd1;
      if ($urandom_range(0, 49) == 0) begin
        set_stb = 1'b1;
        case ($urandom_range(0, 3))
          0:       set_addr = 8'(BASE);
          1:       set_addr = 8'(BASE + 1);
          2:       set_addr = 8'(BASE + 2);
          default: set_addr = 8'h00;
        endcase
        set_data = $urandom;
      end else begin
        set_stb = 1'b0;
      end
      // Keep both channels mostly running.
      if ($urandom_range(0, 199) == 0) begin
        set_stb = 1'b1; set_addr = 8'(BASE); set_data = 32'h3;
      end
      step();
    end
    idle();
    o_tready = 1'b1;
    repeat (20) step();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
